// File: rtl/pixel_streamer.sv
// Fetches packed words from a synchronous frame memory, unpacks PIX_PER_WORD
// pixels MSB-first and streams them one per cycle over valid/ready with SOF/EOF.
module pixel_streamer #(
  parameter int unsigned PIX_W        = 24,
  parameter int unsigned PIX_PER_WORD = 2,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned N_WORDS      = 32400,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          restart_i,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_rd_o,
  input  logic [PIX_W*PIX_PER_WORD-1:0] data_in_i,
  output logic [PIX_W-1:0]              rgb_o,
  output logic                          rgb_valid_o,
  input  logic                          rgb_ready_i,
  output logic                          sof_o,
  output logic                          eof_o,
  output logic                          busy_o
);

  localparam int unsigned WORD_W = PIX_W * PIX_PER_WORD;
  localparam int unsigned SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int unsigned LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PIX_PER_WORD - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STREAM
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SLOT_W-1:0]   slot_q, slot_d, slot_nxt;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [PIX_W-1:0]    rgb_q, rgb_d;
  logic                rgb_valid_q, rgb_valid_d;
  logic                sof_q, sof_d;
  logic                eof_q, eof_d;
  logic                mem_rd_q, mem_rd_d;
  logic                busy_q, busy_d;

  // Slot 0 is the most significant pixel of the word.
  function automatic logic [PIX_W-1:0] pick(input logic [WORD_W-1:0] word,
                                            input logic [SLOT_W-1:0] slot);
    int unsigned shamt;
    shamt = PIX_W * (PIX_PER_WORD - 1 - 32'(slot));
    return PIX_W'(word >> shamt);
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    slot_d      = slot_q;
    slot_nxt    = slot_q + SLOT_W'(1);
    lat_d       = lat_q;
    word_d      = word_q;
    rgb_d       = rgb_q;
    rgb_valid_d = rgb_valid_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    mem_rd_d    = 1'b0;
    busy_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_REQ;
      end
      S_REQ: begin
        lat_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d     = S_STREAM;
          lat_d       = '0;
          word_d      = data_in_i;
          slot_d      = '0;
          rgb_d       = pick(data_in_i, '0);
          rgb_valid_d = 1'b1;
          sof_d       = (addr_q == '0);
          eof_d       = (addr_q == ADDR_LAST) && (SLOT_LAST == '0);
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_STREAM: begin
        if (rgb_ready_i) begin
          sof_d = 1'b0;
          if (slot_q == SLOT_LAST) begin
            rgb_valid_d = 1'b0;
            eof_d       = 1'b0;
            slot_d      = '0;
            addr_d      = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
            state_d     = enable_i ? S_REQ : S_IDLE;
          end else begin
            slot_d = slot_nxt;
            rgb_d  = pick(word_q, slot_nxt);
            eof_d  = (addr_q == ADDR_LAST) && (slot_nxt == SLOT_LAST);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything in flight, including a same-cycle handshake.
    if (restart_i) begin
      state_d     = S_IDLE;
      addr_d      = '0;
      slot_d      = '0;
      lat_d       = '0;
      rgb_valid_d = 1'b0;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
    end

    mem_rd_d = (state_d == S_REQ);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      slot_q      <= '0;
      lat_q       <= '0;
      word_q      <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      slot_q      <= slot_d;
      lat_q       <= lat_d;
      word_q      <= word_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      mem_rd_q    <= mem_rd_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_rd_o    = mem_rd_q;
  assign rgb_o       = rgb_q;
  assign rgb_valid_o = rgb_valid_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;
  assign busy_o      = busy_q;

endmodule
